rv_fetch_aligner: RTL and testbench

- Sits between the instruction fetch unit and the decoder; its output feeds the instr_type/cinstr_type decode.
- Accepts sequential 32-bit fetch words and queues them as 16-bit halfwords.
- Re-aligns 32-bit instructions that straddle word boundaries and separates compressed (16-bit) instructions.
- Presents one instruction per cycle, with its PC and a compressed flag, over a valid/ready handshake.

---
 rtl/rv_fetch_aligner.sv | 134 +++++++++++++
 tb/tb_rv_fetch_aligner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_aligner.sv
// Fetch-word to instruction aligner: queues 32-bit fetch words as halfwords and
// presents one compressed or 32-bit instruction per cycle with its PC.
module rv_fetch_aligner #(
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  localparam int unsigned PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int unsigned CW = $clog2(BUF_HW + 1);

  logic [15:0]   buf_q [BUF_HW];
  logic [15:0]   buf_d [BUF_HW];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          need_pc_q, need_pc_d;
  logic [31:0]   out_data_q, out_data_d, out_pc_q, out_pc_d;
  logic          out_c_q, out_c_d;

  logic [PW-1:0] head1, tail1;
  logic [15:0]   hw0, hw1;
  logic          is32, avail, push, pop, push_hi_only;
  logic [31:0]   cur_data;
  logic [CW-1:0] push_n, pop_n;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_HW - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head1        = wrap_inc(head_q);
  assign tail1        = wrap_inc(tail_q);
  assign hw0          = buf_q[head_q];
  assign hw1          = buf_q[head1];
  assign is32         = (hw0[1:0] == 2'b11);
  assign avail        = is32 ? (count_q >= CW'(2)) : (count_q >= CW'(1));
  assign cur_data     = is32 ? {hw1, hw0} : {16'h0000, hw0};
  assign instr_valid  = avail && !flush && !need_pc_q;
  assign fetch_ready  = !flush && (count_q <= CW'(BUF_HW - 2));
  assign push         = fetch_valid && fetch_ready;
  assign pop          = instr_valid && instr_ready;
  assign push_hi_only = need_pc_q && fetch_addr[1];
  assign push_n       = push ? (push_hi_only ? CW'(1) : CW'(2)) : '0;
  assign pop_n        = pop ? (is32 ? CW'(2) : CW'(1)) : '0;

  // While invalid, outputs replay the last presented instruction so nothing
  // downstream sees stale queue contents or X after reset.
  assign instr_data       = instr_valid ? cur_data  : out_data_q;
  assign instr_pc         = instr_valid ? head_pc_q : out_pc_q;
  assign instr_compressed = instr_valid ? !is32     : out_c_q;

  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    need_pc_d  = need_pc_q;
    out_data_d = out_data_q;
    out_pc_d   = out_pc_q;
    out_c_d    = out_c_q;
    if (instr_valid) begin
      out_data_d = cur_data;
      out_pc_d   = head_pc_q;
      out_c_d    = !is32;
    end
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      need_pc_d = 1'b1;
    end else begin
      if (push) begin
        if (push_hi_only) begin
          buf_d[tail_q] = fetch_data[31:16];
          tail_d        = tail1;
        end else begin
          buf_d[tail_q] = fetch_data[15:0];
          buf_d[tail1]  = fetch_data[31:16];
          tail_d        = wrap_inc(tail1);
        end
        if (need_pc_q) begin
          need_pc_d = 1'b0;
          head_pc_d = push_hi_only ? fetch_addr : {fetch_addr[31:1], 1'b0};
        end
      end
      // Pop never coincides with a PC-establishing push: need_pc gates instr_valid.
      if (pop) begin
        head_d    = is32 ? wrap_inc(head1) : head1;
        head_pc_d = head_pc_q + (is32 ? 32'd4 : 32'd2);
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      head_pc_q  <= RESET_PC;
      need_pc_q  <= 1'b1;
      out_data_q <= '0;
      out_pc_q   <= RESET_PC;
      out_c_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      need_pc_q  <= need_pc_d;
      out_data_q <= out_data_d;
      out_pc_q   <= out_pc_d;
      out_c_q    <= out_c_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BUF_HW; i++) buf_q[i] <= buf_d[i];
  end

endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Directed bench for rv_fetch_aligner with a halfword-queue reference model
// checked every cycle and hand-computed expectations per scenario.
module tb_rv_fetch_aligner;

  localparam int unsigned BUF_HW   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst, flush, fetch_valid, fetch_ready, instr_valid, instr_ready, instr_compressed;
  logic [31:0] fetch_addr, fetch_data, instr_data, instr_pc;

  rv_fetch_aligner #(.BUF_HW(BUF_HW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_compressed(instr_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        c;
  } ent_t;
  ent_t        log_q[$];
  int unsigned li = 0;

  // Reference model: a plain queue of halfwords plus the PC of its head.
  logic [15:0] mq[$];
  logic [31:0] mpc   = RESET_PC;
  bit          mneed = 1'b1;
  bit          mvalid, mc, mready;
  logic [31:0] mdata;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mpc   = RESET_PC;
      mneed = 1'b1;
    end else begin
      mready = !flush && (mq.size() <= BUF_HW - 2);
      mvalid = 1'b0;
      mc     = 1'b0;
      mdata  = '0;
      if (!flush && !mneed && mq.size() >= 1) begin
        if (mq[0][1:0] != 2'b11) begin
          mvalid = 1'b1; mc = 1'b1; mdata = {16'h0000, mq[0]};
        end else if (mq.size() >= 2) begin
          mvalid = 1'b1; mc = 1'b0; mdata = {mq[1], mq[0]};
        end
      end
      chk("instr_valid", instr_valid, mvalid);
      chk("fetch_ready", fetch_ready, mready);
      if (mvalid) begin
        chk("instr_data", instr_data, mdata);
        chk("instr_pc", instr_pc, mpc);
        chk("instr_compressed", instr_compressed, mc);
      end
      if (flush) begin
        mq.delete();
        mneed = 1'b1;
      end else begin
        if (mvalid && instr_ready) begin
          log_q.push_back('{mpc, mdata, mc});
          void'(mq.pop_front());
          if (!mc) void'(mq.pop_front());
          mpc = mpc + (mc ? 32'd2 : 32'd4);
        end
        if (fetch_valid && mready) begin
          if (mneed && fetch_addr[1]) begin
            mq.push_back(fetch_data[31:16]);
            mpc = fetch_addr;
          end else begin
            mq.push_back(fetch_data[15:0]);
            mq.push_back(fetch_data[31:16]);
            if (mneed) mpc = {fetch_addr[31:1], 1'b0};
          end
          mneed = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, output int unsigned stalls);
    bit done;
    done        = 1'b0;
    stalls      = 0;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    fetch_data  = d;
    for (int k = 0; k < 32 && !done; k++) begin
      @(negedge clk);
      if (fetch_ready) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    fetch_valid = 1'b0;
    chk("push_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic exp_log(input string name, input logic [31:0] pc, input logic [31:0] data, input logic c);
    if (li < log_q.size()) begin
      chk({name, "_pc"}, log_q[li].pc, pc);
      chk({name, "_data"}, log_q[li].data, data);
      chk({name, "_c"}, {31'b0, log_q[li].c}, {31'b0, c});
    end else begin
      chk({name, "_present"}, log_q.size(), li + 1);
    end
    li++;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({name, "_data"}, instr_data, 32'd0);
    chk({name, "_pc"}, instr_pc, RESET_PC);
    chk({name, "_c"}, {31'b0, instr_compressed}, 32'd0);
    chk({name, "_fready"}, {31'b0, fetch_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int unsigned st, total;

  initial begin
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0; instr_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    #9 rst = 1'b0;
    step(1);

    // Aligned 32-bit instruction
    instr_ready = 1'b1;
    push(32'h100, 32'h0000_0093, st);
    chk("aligned_valid", {31'b0, instr_valid}, 32'd1);
    chk("aligned_data", instr_data, 32'h0000_0093);
    chk("aligned_pc", instr_pc, 32'h100);
    chk("aligned_c", {31'b0, instr_compressed}, 32'd0);
    step(1);
    chk("aligned_after", {31'b0, instr_valid}, 32'd0);
    step(1);
    exp_log("aligned", 32'h100, 32'h0000_0093, 1'b0);

    // Two compressed in one word
    do_flush();
    push(32'h200, 32'h4505_4501, st);
    step(3);
    exp_log("c0", 32'h200, 32'h0000_4501, 1'b1);
    exp_log("c1", 32'h202, 32'h0000_4505, 1'b1);

    // Straddling 32-bit instruction
    do_flush();
    push(32'h300, 32'h0093_4501, st);
    push(32'h304, 32'h1234_0000, st);
    step(4);
    exp_log("str0", 32'h300, 32'h0000_4501, 1'b1);
    exp_log("str1", 32'h302, 32'h0000_0093, 1'b0);
    exp_log("str2", 32'h306, 32'h0000_1234, 1'b1);

    // Start on the upper halfword
    do_flush();
    push(32'h402, 32'h4505_FFFF, st);
    step(3);
    exp_log("hwstart", 32'h402, 32'h0000_4505, 1'b1);
    chk("hwstart_count", log_q.size(), li);

    // Backpressure fills the queue
    do_flush();
    instr_ready = 1'b0;
    push(32'h100, 32'h0000_0093, st);
    push(32'h104, 32'h0000_0093, st);
    chk("bp_fready_low", {31'b0, fetch_ready}, 32'd0);
    chk("bp_valid", {31'b0, instr_valid}, 32'd1);
    chk("bp_data", instr_data, 32'h0000_0093);
    chk("bp_pc", instr_pc, 32'h100);
    step(2);
    chk("bp_data_stable", instr_data, 32'h0000_0093);
    chk("bp_pc_stable", instr_pc, 32'h100);
    instr_ready = 1'b1;
    step(3);
    chk("bp_fready_high", {31'b0, fetch_ready}, 32'd1);
    exp_log("bp0", 32'h100, 32'h0000_0093, 1'b0);
    exp_log("bp1", 32'h104, 32'h0000_0093, 1'b0);

    // Flush drops a partial instruction
    do_flush();
    instr_ready = 1'b0;
    push(32'h600, 32'h0093_4501, st);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    flush = 1'b1;
    #1 chk("flush_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_need_pc", {31'b0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    push(32'h800, 32'h0000_0013, st);
    step(2);
    exp_log("fl0", 32'h600, 32'h0000_4501, 1'b1);
    exp_log("fl1", 32'h800, 32'h0000_0013, 1'b0);
    chk("flush_count", log_q.size(), li);

    // Asynchronous reset mid-operation
    do_flush();
    instr_ready = 1'b0;
    push(32'h600, 32'h0093_4501, st);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    step(1);
    instr_ready = 1'b1;
    push(32'h800, 32'h0000_0013, st);
    step(2);
    exp_log("rs0", 32'h600, 32'h0000_4501, 1'b1);
    exp_log("rs1", 32'h800, 32'h0000_0013, 1'b0);

    // Steady 32-bit stream must not stall
    do_flush();
    instr_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 7), st);
      total += st;
    end
    step(3);
    chk("stream_stalls", total, 32'd0);
    for (int i = 0; i < 8; i++)
      exp_log("stream", 32'h1000 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 7), 1'b0);
    chk("log_total", log_q.size(), li);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
